// File: rtl/fetch_unit_if.sv
// Instruction-bus channel between the fetch stage (master) and the memory side (slave).
// Split handshake: address accepted on addr_ok, read data returned later on data_ok.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_addr_ok;
  logic              iresp_data_ok;
  logic [31:0]       iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch-stage bus master: one request per fetch PC, holds the instruction until decode takes it.
// FETCH_ADEL_EN: misaligned PCs skip the bus and return a NOP flagged with exc_adel.
module fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] pc_f,
  input  logic              valid_f,
  input  logic              stall_d,
  input  logic              flush_d,
  fetch_unit_if.master      ibus,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  output logic              exc_adel,
  output logic              fetch_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_VALID
  } state_t;

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] pc_q;
  logic              drop_q;
  logic              free, accept, misalign, kill;
  logic              addr_ok, data_ok;
  logic              capture, retire, issue, adel_take;

  assign addr_ok = ibus.iresp_addr_ok;
  assign data_ok = ibus.iresp_data_ok;
  assign free    = (state_q == S_IDLE) || (state_q == S_VALID && !stall_d);
  assign accept  = !flush_d && valid_f && free;
  // A flush seen earlier in ADDR still has to drop the response once it arrives.
  assign kill    = flush_d || drop_q;

`ifdef FETCH_ADEL_EN
  assign misalign = (pc_f[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_nx = misalign ? S_VALID : S_ADDR;
      S_ADDR: begin
        if (addr_ok) begin
          if (data_ok) state_nx = kill ? S_IDLE : S_VALID;
          else         state_nx = kill ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (data_ok)      state_nx = flush_d ? S_IDLE : S_VALID;
        else if (flush_d) state_nx = S_DRAIN;
      end
      S_DRAIN: if (data_ok) state_nx = S_IDLE;
      S_VALID: begin
        if (flush_d)       state_nx = S_IDLE;
        else if (!stall_d) state_nx = accept ? (misalign ? S_VALID : S_ADDR) : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_busy = !free;
    issue      = accept && !misalign;
    adel_take  = accept && misalign;
    retire     = (state_q == S_VALID) && (flush_d || !stall_d);
    capture    = (state_q == S_ADDR && addr_ok && data_ok && !kill) ||
                 (state_q == S_DATA && data_ok && !flush_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q            <= '0;
      drop_q          <= 1'b0;
      ibus.ireq_valid <= 1'b0;
      ibus.ireq_addr  <= '0;
      instr_out       <= NOP_INSTR;
      pc_out          <= '0;
      instr_valid     <= 1'b0;
    end else begin
      ibus.ireq_valid <= (state_nx == S_ADDR);
      if (issue) begin
        pc_q   <= pc_f;
        drop_q <= 1'b0;
`ifdef FETCH_ADEL_EN
        ibus.ireq_addr <= pc_f;
`else
        ibus.ireq_addr <= {pc_f[ADDR_W-1:2], 2'b00};
`endif
      end else if (state_q == S_ADDR && flush_d) begin
        drop_q <= 1'b1;
      end
      if (retire) begin
        instr_valid <= 1'b0;
        instr_out   <= NOP_INSTR;
      end
      if (capture) begin
        instr_valid <= 1'b1;
        instr_out   <= ibus.iresp_data;
        pc_out      <= pc_q;
      end
      if (adel_take) begin
        instr_valid <= 1'b1;
        instr_out   <= NOP_INSTR;
        pc_out      <= pc_f;
      end
    end
  end

`ifdef FETCH_ADEL_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        exc_adel <= 1'b0;
    else if (adel_take) exc_adel <= 1'b1;
    else if (retire || capture) exc_adel <= 1'b0;
  end
`else
  assign exc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; deliveries are checked by a scoreboard monitor at consumption.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pc_f;
  logic        valid_f, stall_d, flush_d;
  logic [31:0] instr_out, pc_out;
  logic        instr_valid, exc_adel, fetch_busy;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(32)) ibus ();

  fetch_unit #(.NOP_INSTR(32'h0), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .pc_f(pc_f), .valid_f(valid_f),
    .stall_d(stall_d), .flush_d(flush_d), .ibus(ibus),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .exc_adel(exc_adel), .fetch_busy(fetch_busy)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ireq_valid"}, ibus.ireq_valid, 0);
    chk({tag, "_ireq_addr"}, ibus.ireq_addr, 0);
    chk({tag, "_instr_out"}, instr_out, 0);
    chk({tag, "_pc_out"}, pc_out, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_exc_adel"}, exc_adel, 0);
    chk({tag, "_fetch_busy"}, fetch_busy, 0);
  endtask

  // An instruction is consumed on the edge following a valid, unstalled, unflushed cycle.
  always @(negedge clk) begin
    if (resetn === 1'b1 && instr_valid === 1'b1 && !stall_d && !flush_d) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery: got pc %0h instr %0h, expected none", pc_out, instr_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("deliver_instr", instr_out, e.instr);
        chk("deliver_pc", pc_out, e.pc);
        chk("deliver_adel", exc_adel, e.adel);
      end
    end
  end

  initial begin
    resetn = 1'b0; pc_f = '0; valid_f = 0; stall_d = 0; flush_d = 0;
    ibus.iresp_addr_ok = 0; ibus.iresp_data_ok = 0; ibus.iresp_data = '0;
    repeat (2) step();
    chk_reset_vals("reset");
    #2 resetn = 1'b1;
    step();

    // Basic fetch: addr_ok in first ADDR cycle, data one cycle later
    valid_f = 1; pc_f = 32'hbfc00000;
    sb.push_back('{32'h24080001, 32'hbfc00000, 1'b0});
    #1 chk("idle_busy", fetch_busy, 0);
    step();
    valid_f = 0;
    #1;
    chk("basic_ireq_valid", ibus.ireq_valid, 1);
    chk("basic_ireq_addr", ibus.ireq_addr, 32'hbfc00000);
    chk("basic_addr_busy", fetch_busy, 1);
    ibus.iresp_addr_ok = 1;
    step();
    ibus.iresp_addr_ok = 0;
    #1;
    chk("basic_data_ireq_valid", ibus.ireq_valid, 0);
    chk("basic_data_busy", fetch_busy, 1);
    ibus.iresp_data_ok = 1; ibus.iresp_data = 32'h24080001;
    stall_d = 1; valid_f = 1; pc_f = 32'hbfc00004;
    step();
    ibus.iresp_data_ok = 0;
    chk("basic_instr_valid", instr_valid, 1);
    chk("basic_instr_out", instr_out, 32'h24080001);
    chk("basic_pc_out", pc_out, 32'hbfc00000);

    // Decode stall holds everything and blocks the next request
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_busy", fetch_busy, 1);
      chk("stall_ireq_valid", ibus.ireq_valid, 0);
      chk("stall_instr_out", instr_out, 32'h24080001);
      step();
    end
    stall_d = 0;
    sb.push_back('{32'h8c090004, 32'hbfc00004, 1'b0});
    #1 chk("unstall_busy", fetch_busy, 0);
    step();
    valid_f = 0;
    chk("next_ireq_valid", ibus.ireq_valid, 1);
    chk("next_ireq_addr", ibus.ireq_addr, 32'hbfc00004);
    chk("next_addr_instr_valid", instr_valid, 0);
    chk("next_addr_instr_nop", instr_out, 0);
    ibus.iresp_addr_ok = 1; ibus.iresp_data_ok = 1; ibus.iresp_data = 32'h8c090004;
    step();
    ibus.iresp_addr_ok = 0; ibus.iresp_data_ok = 0;
    chk("sameclk_instr_valid", instr_valid, 1);
    step();
    #1;
    chk("idle_instr_valid", instr_valid, 0);
    chk("idle_instr_nop", instr_out, 0);
    chk("idle_busy2", fetch_busy, 0);

    // Flush during ADDR: request stays up, response dropped
    valid_f = 1; pc_f = 32'hbfc00000;
    step();
    valid_f = 0; flush_d = 1;
    chk("flush_addr_ireq", ibus.ireq_valid, 1);
    step();
    flush_d = 0;
    chk("flush_addr_hold1", ibus.ireq_valid, 1);
    step();
    chk("flush_addr_hold2", ibus.ireq_valid, 1);
    ibus.iresp_addr_ok = 1;
    step();
    ibus.iresp_addr_ok = 0;
    #1;
    chk("drain_ireq_valid", ibus.ireq_valid, 0);
    chk("drain_busy", fetch_busy, 1);
    chk("drain_instr_valid", instr_valid, 0);
    ibus.iresp_data_ok = 1; ibus.iresp_data = 32'hdeadbeef;
    step();
    ibus.iresp_data_ok = 0;
    #1;
    chk("drained_instr_valid", instr_valid, 0);
    chk("drained_busy", fetch_busy, 0);
    step();
    chk("drained_instr_valid2", instr_valid, 0);

    // Flush and data_ok collide in DATA
    valid_f = 1; pc_f = 32'hbfc00008;
    step();
    valid_f = 0; ibus.iresp_addr_ok = 1;
    step();
    ibus.iresp_addr_ok = 0;
    ibus.iresp_data_ok = 1; ibus.iresp_data = 32'h11111111; flush_d = 1;
    step();
    ibus.iresp_data_ok = 0; flush_d = 0;
    #1;
    chk("collide_instr_valid", instr_valid, 0);
    chk("collide_busy", fetch_busy, 0);
    chk("collide_ireq_valid", ibus.ireq_valid, 0);
    step();
    chk("collide_instr_valid2", instr_valid, 0);

    // Flush in VALID wins over stall_d and valid_f
    valid_f = 1; pc_f = 32'hbfc0000c;
    step();
    valid_f = 0; ibus.iresp_addr_ok = 1; ibus.iresp_data_ok = 1; ibus.iresp_data = 32'h22222222;
    step();
    ibus.iresp_addr_ok = 0; ibus.iresp_data_ok = 0;
    stall_d = 1; valid_f = 1; pc_f = 32'hbfc00010; flush_d = 1;
    chk("vflush_pre_valid", instr_valid, 1);
    chk("vflush_pre_pc", pc_out, 32'hbfc0000c);
    step();
    flush_d = 0; valid_f = 0; stall_d = 0;
    chk("vflush_instr_valid", instr_valid, 0);
    chk("vflush_instr_nop", instr_out, 0);
    step();
    chk("vflush_no_req", ibus.ireq_valid, 0);

    // Asynchronous reset in the middle of DATA
    valid_f = 1; pc_f = 32'hbfc00010;
    step();
    valid_f = 0; ibus.iresp_addr_ok = 1;
    step();
    ibus.iresp_addr_ok = 0;
    chk("pre_reset_addr", ibus.ireq_addr, 32'hbfc00010);
    #2 resetn = 1'b0;
    #1 chk_reset_vals("midreset");
    step();
    resetn = 1'b1;
    step();
    chk("post_reset_busy", fetch_busy, 0);
    chk("post_reset_ireq", ibus.ireq_valid, 0);

`ifdef FETCH_ADEL_EN
    valid_f = 1; pc_f = 32'hbfc00002;
    sb.push_back('{32'h0, 32'hbfc00002, 1'b1});
    step();
    valid_f = 0;
    chk("adel_no_req", ibus.ireq_valid, 0);
    chk("adel_flag", exc_adel, 1);
    chk("adel_instr_valid", instr_valid, 1);
    chk("adel_pc_out", pc_out, 32'hbfc00002);
    chk("adel_instr_nop", instr_out, 0);
    step();
    chk("adel_clear", exc_adel, 0);
    chk("adel_clear_valid", instr_valid, 0);
`else
    valid_f = 1; pc_f = 32'hbfc00002;
    sb.push_back('{32'h33333333, 32'hbfc00002, 1'b0});
    step();
    valid_f = 0;
    chk("mis_ireq_addr", ibus.ireq_addr, 32'hbfc00000);
    chk("mis_exc_adel", exc_adel, 0);
    ibus.iresp_addr_ok = 1; ibus.iresp_data_ok = 1; ibus.iresp_data = 32'h33333333;
    step();
    ibus.iresp_addr_ok = 0; ibus.iresp_data_ok = 0;
    chk("mis_pc_out", pc_out, 32'hbfc00002);
    step();
    chk("mis_done_valid", instr_valid, 0);
`endif

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch-stage instruction bus master, directly downstream of the fetch PC register.
- Consumes the registered fetch PC and its valid bit, and issues one instruction-bus request per PC using a split address/data handshake.
- Holds the returned instruction for the F/D pipeline register until decode accepts it.
- Raises fetch_busy, which the hazard unit ORs into the PC-register stall. Absorbs flushes, including dropping responses that are already in flight.

Parameters:
- NOP_INSTR, 32'h0000_0000, value driven on instr_out whenever instr_valid=0.
- ADDR_W, 32, width of PC and bus address.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, active-low
- pc_f  in  ADDR_W  fetch PC from PC register
- valid_f  in  1  pc_f holds a real fetch PC
- stall_d  in  1  decode stalled; held instruction must not be consumed
- flush_d  in  1  kill the held instruction and any outstanding fetch
- ireq_valid  out  1  bus request valid
- ireq_addr  out  ADDR_W  bus request address
- iresp_addr_ok  in  1  request accepted this cycle
- iresp_data_ok  in  1  read data returned this cycle
- iresp_data  in  32  instruction word
- instr_out  out  32  instruction to F/D register
- pc_out  out  ADDR_W  PC of instr_out
- instr_valid  out  1  instr_out/pc_out valid
- exc_adel  out  1  fetch address error (see Optional Feature)
- fetch_busy  out  1  stall request to PC register

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; ireq_valid=0; ireq_addr=0; instr_out=NOP_INSTR; pc_out=0; instr_valid=0; exc_adel=0.
- Reset mid-transaction discards everything. The bus slave is reset by the same resetn.
- States: IDLE, ADDR, DATA, DRAIN, VALID.
- accept = ~flush_d & valid_f & (state==IDLE | (state==VALID & ~stall_d)).
- fetch_busy = ~(state==IDLE | (state==VALID & ~stall_d)). This is combinational.
- On accept: pc_q<=pc_f, ireq_addr<=pc_f, next state ADDR. The request is registered, so ireq_valid rises the cycle after accept.
- ADDR (ireq_valid=1, stays high until addr_ok; never withdrawn, even on flush):
  - addr_ok & data_ok in the same cycle: capture the instruction, go to VALID.
  - addr_ok alone: go to DATA.
  - flush_d, or an earlier flush remembered in drop flag drop_q: on addr_ok go to DRAIN; on addr_ok & data_ok go to IDLE with no output.
- DATA (ireq_valid=0):
  - data_ok: capture instr_out<=iresp_data, pc_out<=pc_q, instr_valid<=1, go to VALID.
  - flush_d without data_ok: go to DRAIN.
  - flush_d with data_ok: discard, go to IDLE.
- DRAIN: wait for data_ok, discard the data, go to IDLE. instr_valid=0 throughout.
- VALID (instr_valid=1):
  - stall_d=1: hold all outputs.
  - stall_d=0: the instruction is consumed at this edge. If accept, go to ADDR; otherwise clear instr_valid and go to IDLE.
  - flush_d: clear instr_valid, go to IDLE. Flush wins over stall_d and over valid_f.
- valid_f=0 never starts a request; pc_f is ignored.
- At most one outstanding request; no speculative prefetch.
- Best-case throughput: one instruction per 2 cycles (accept, then ADDR with same-cycle addr_ok/data_ok).

Optional Feature:
- Macro: FETCH_ADEL_EN.
- Defined: on accept with pc_f[1:0]!=0, no bus request is issued. Next state is VALID directly with instr_out=NOP_INSTR, pc_out=pc_f, exc_adel=1, instr_valid=1. exc_adel clears whenever instr_valid clears or a new capture occurs.
- Undefined: exc_adel is tied 0; ireq_addr[1:0] is forced to 0 and the fetch proceeds normally.

Test Plan:
- Reset: resetn=0 mid-DATA -> all outputs at reset values immediately; after release state IDLE, fetch_busy=0.
- Basic fetch: valid_f=1, pc_f=32'hbfc00000, slave gives addr_ok in the first ADDR cycle and data_ok one cycle later with 32'h24080001 -> instr_valid=1, instr_out=32'h24080001, pc_out=32'hbfc00000; fetch_busy=1 during ADDR/DATA.
- Decode stall: stall_d=1 for 3 cycles while VALID -> outputs unchanged and fetch_busy=1; no ireq_valid until stall_d drops, then the next PC 32'hbfc00004 is requested.
- Flush in ADDR: flush_d pulse before addr_ok -> ireq_valid stays 1 until addr_ok; the returned data is dropped; instr_valid never rises for 32'hbfc00000.
- Flush/data collision: flush_d and data_ok in the same DATA cycle -> IDLE next cycle, instr_valid=0.
- With FETCH_ADEL_EN: pc_f=32'hbfc00002 -> no ireq_valid; next cycle exc_adel=1, instr_valid=1, pc_out=32'hbfc00002, instr_out=32'h0.
